// File: rtl/display_pkg.sv
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types and constants for the sum_display output stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    localparam int         SHIFT_CYCLES = 12;
    localparam logic [6:0] SEG_OFF      = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [0:9][6:0] SEG_TABLE = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Double-dabble correction applied to the scratch before each shift
    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_7seg.sv
// ============================================================================
//  Module      : bcd_to_7seg
//  Description : Combinational BCD nibble to active-low 7-segment decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (digit_i <= 4'd9) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sum_display.sv
// ============================================================================
//  Module      : sum_display
//  Description : Continuous 12-bit binary to BCD conversion driving a
//                multiplexed 4-digit common-anode 7-segment display.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sum_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 27000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [11:0] sum,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int                 c_CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]         c_SHIFT_LAST = 4'(SHIFT_CYCLES - 1);

    conv_state_e state_q;
    logic [11:0] bin_q;
    logic [15:0] scratch_q;
    logic [3:0]  shift_cnt_q;
    logic [15:0] bcd_q;
    logic        bcd_valid_q;
    logic [27:0] shift_d;

    logic [c_CNT_W-1:0] refresh_q;
    logic [1:0]         idx_q;
    logic [3:0]         digit_d;
    logic               blank_d;
    logic [6:0]         seg_dec;
    logic [6:0]         seg_q;
    logic [3:0]         an_q;

    assign shift_d = {dabble_adjust(scratch_q), bin_q} << 1;

    // Conversion FSM; bcd only ever loads a finished scratch in DONE
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            scratch_q   <= '0;
            shift_cnt_q <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bin_q       <= sum;
                    scratch_q   <= '0;
                    shift_cnt_q <= '0;
                    state_q     <= SHIFT;
                end
                SHIFT: begin
                    scratch_q   <= shift_d[27:12];
                    bin_q       <= shift_d[11:0];
                    shift_cnt_q <= shift_cnt_q + 4'd1;
                    if (shift_cnt_q == c_SHIFT_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q       <= scratch_q;
                    bcd_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else if (refresh_q == c_CNT_MAX) begin
            refresh_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    assign digit_d = bcd_q[{idx_q, 2'b00} +: 4];

    // A digit is blank when it and every more significant digit are zero
    always_comb begin
        blank_d = 1'b0;
        if (BLANK_LZ) begin
            case (idx_q)
                2'd1:    blank_d = (bcd_q[15:4]  == 12'd0);
                2'd2:    blank_d = (bcd_q[15:8]  == 8'd0);
                2'd3:    blank_d = (bcd_q[15:12] == 4'd0);
                default: blank_d = 1'b0;
            endcase
        end
    end

    bcd_to_7seg u_dec (
        .digit_i (digit_d),
        .seg_o   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!n_reset || !bcd_valid_q) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_OFF;
        end else begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= blank_d ? SEG_OFF : seg_dec;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_display.sv
// ============================================================================
//  Module      : tb_sum_display
//  Description : Scoreboard bench for sum_display with a decimal reference.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sum_display;

    localparam int RD = 4;

    logic        clk;
    logic        n_reset;
    logic [11:0] sum;
    logic [15:0] bcd,  bcd_nb;
    logic        bcd_valid, bcd_valid_nb;
    logic [6:0]  seg,  seg_nb;
    logic [3:0]  an,   an_nb;

    sum_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .n_reset(n_reset), .sum(sum), .bcd(bcd),
        .bcd_valid(bcd_valid), .seg(seg), .an(an)
    );

    sum_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .n_reset(n_reset), .sum(sum), .bcd(bcd_nb),
        .bcd_valid(bcd_valid_nb), .seg(seg_nb), .an(an_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               due;
        logic [15:0]      bcd;
        logic [3:0][6:0]  seg_b;
        logic [3:0][6:0]  seg_nb;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Decimal reference: digits by division, blanking by magnitude
    function automatic exp_t model(input int v, input int due);
        exp_t e;
        int   p;
        int   d;
        p     = 1;
        e.due = due;
        for (int k = 0; k < 4; k++) begin
            d               = (v / p) % 10;
            e.bcd[4*k +: 4] = 4'(d);
            e.seg_nb[k]     = seg_of(d);
            e.seg_b[k]      = (k > 0 && v < p) ? 7'b1111111 : seg_of(d);
            p               = p * 10;
        end
        return e;
    endfunction

    // Monitor: once a value is due, check bcd and a full scan window
    initial begin : monitor
        exp_t       e;
        int         idx;
        int         run;
        bit         started;
        logic [3:0] prev_an;
        logic [3:0] seen;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
                mon_busy = 1'b1;
                e = sb_q.pop_front();
                chk("bcd", 32'(bcd), 32'(e.bcd));
                chk("bcd_valid", 32'(bcd_valid), 1);
                chk("bcd_noblank", 32'(bcd_nb), 32'(e.bcd));
                prev_an = an; run = 0; started = 1'b0; seen = 4'b0000;
                for (int c = 0; c < 4*RD + 4; c++) begin
                    case (an)
                        4'b1110: idx = 0;
                        4'b1101: idx = 1;
                        4'b1011: idx = 2;
                        4'b0111: idx = 3;
                        default: idx = -1;
                    endcase
                    chk("an_onehot", 32'(an), (idx < 0) ? 32'hE : 32'(an));
                    chk("an_noblank", 32'(an_nb), 32'(an));
                    if (idx >= 0) begin
                        seen[idx] = 1'b1;
                        chk($sformatf("seg_d%0d", idx), 32'(seg), 32'(e.seg_b[idx]));
                        chk($sformatf("seg_noblank_d%0d", idx), 32'(seg_nb), 32'(e.seg_nb[idx]));
                    end
                    if (an != prev_an) begin
                        if (started) chk("an_hold", run, RD);
                        started = 1'b1;
                        run     = 1;
                        prev_an = an;
                    end else begin
                        run++;
                    end
                    @(negedge clk);
                end
                chk("scan_all_digits", 32'(seen), 32'hF);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 500), 1);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_valid", 32'(bcd_valid), 0);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an_noblank", 32'(an_nb), 32'hF);
        chk("rst_seg_noblank", 32'(seg_nb), 32'h7F);
    endtask

    initial begin : stim
        int vals[$];
        bit got;
        n_reset = 1'b0;
        sum     = 12'd698;
        edges(3);
        chk_reset_state();

        n_reset = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 15 && !got; i++) begin
            edges(1);
            if (bcd_valid) got = 1'b1;
        end
        chk("first_valid", 32'(bcd_valid), 1);
        chk("bcd_698", 32'(bcd), 32'h0698);
        sb_q.push_back(model(698, cyc));
        drain();

        vals = '{0, 4095, 7, 9, 10, 99, 100, 1000, 1009};
        for (int i = 0; i < 6; i++) vals.push_back(int'($urandom_range(0, 4095)));
        foreach (vals[i]) begin
            @(negedge clk);
            sum = 12'(vals[i]);
            sb_q.push_back(model(vals[i], cyc + 28));
            drain();
        end

        // Known phase from reset: first edge after release captures sum
        @(negedge clk);
        n_reset = 1'b0;
        sum     = 12'd100;
        edges(1);
        n_reset = 1'b1;
        edges(5);
        sum = 12'd3000;
        edges(8);
        chk("chg_valid_before", 32'(bcd_valid), 0);
        edges(1);
        chk("chg_valid", 32'(bcd_valid), 1);
        chk("chg_first", 32'(bcd), 32'h0100);
        edges(13);
        chk("chg_stable", 32'(bcd), 32'h0100);
        edges(1);
        chk("chg_second", 32'(bcd), 32'h3000);

        // Now in the fourth SHIFT cycle of the next conversion
        edges(4);
        n_reset = 1'b0;
        edges(1);
        chk_reset_state();
        sum     = 12'd2021;
        n_reset = 1'b1;
        edges(13);
        chk("rst_mid_valid_before", 32'(bcd_valid), 0);
        edges(1);
        chk("rst_mid_valid", 32'(bcd_valid), 1);
        chk("rst_mid_bcd", 32'(bcd), 32'h2021);
        sb_q.push_back(model(2021, cyc));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
